// File: rtl/mem_io_responder.sv
// Byte-wide memory/IO responder: 128KB RAM, UART rx/tx byte port, cycle counter and program-stop.
// Latency: reads return on mem_din one cycle after the read edge; writes complete at the same edge.
// Backpressure: tx FIFO raises io_buffer_full early and drops pushes when full (tx_overflow); COUNTER_SNAPSHOT_EN adds a coherent counter snapshot.
module mem_io_responder #(
    parameter int    ADDR_WIDTH  = 17,
    parameter int    TX_DEPTH    = 16,
    parameter int    FULL_MARGIN = 2,
    parameter string INIT_FILE   = ""
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic [31:0] mem_a,
    input  logic [7:0]  mem_dout,
    input  logic        mem_wr,
    output logic [7:0]  mem_din,
    output logic        io_buffer_full,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ack,
    output logic        prog_stop,
    output logic        tx_overflow
);
    localparam int PW = $clog2(TX_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(TX_DEPTH);
    localparam logic [CW-1:0] FULL_AT = CW'(TX_DEPTH - FULL_MARGIN);

    logic [7:0] ram    [0:(2**ADDR_WIDTH)-1];
    logic [7:0] tx_mem [0:TX_DEPTH-1];

    logic [7:0]    mem_din_q, mem_din_d;
    logic          rx_ack_q, rx_ack_d;
    logic          prog_stop_q, prog_stop_d;
    logic          tx_overflow_q, tx_overflow_d;
    logic          io_buffer_full_q, io_buffer_full_d;
    logic [31:0]   cnt_q, cnt_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] fifo_cnt_q, fifo_cnt_d;
`ifdef COUNTER_SNAPSHOT_EN
    logic [31:0]   snap_q, snap_d;
`endif

    logic        is_ram, is_io_uart, is_io_cnt;
    logic        rd_en, wr_en;
    logic        tx_vld, pop, push_req, push_ok;
    logic [7:0]  push_byte, cnt_byte;
    logic [31:0] cnt_src;
    logic        unused_addr;

    assign unused_addr = ^mem_a[31:18];

    // 00/01 is RAM, 10 is unmapped, 11 is IO with mem_a[2] picking UART or counter
    assign is_ram     = ~mem_a[17];
    assign is_io_uart = mem_a[17] & mem_a[16] & ~mem_a[2];
    assign is_io_cnt  = mem_a[17] & mem_a[16] & mem_a[2];
    assign rd_en      = rdy_in & ~mem_wr;
    assign wr_en      = rdy_in & mem_wr;
    assign tx_vld     = (fifo_cnt_q != '0);

`ifdef COUNTER_SNAPSHOT_EN
    assign cnt_src = (mem_a[1:0] == 2'd0) ? cnt_q : snap_q;
`else
    assign cnt_src = cnt_q;
`endif
    assign cnt_byte = 8'(cnt_src >> {mem_a[1:0], 3'b000});

    always_comb begin
        mem_din_d   = mem_din_q;
        rx_ack_d    = 1'b0;
        prog_stop_d = prog_stop_q;
        push_req    = 1'b0;
        push_byte   = mem_dout;
        cnt_d       = cnt_q + 32'd1;
`ifdef COUNTER_SNAPSHOT_EN
        snap_d      = snap_q;
`endif
        if (rd_en) begin
            if (is_ram) begin
                mem_din_d = ram[mem_a[ADDR_WIDTH-1:0]];
            end else if (is_io_uart) begin
                mem_din_d = rx_valid ? rx_data : 8'h00;
                rx_ack_d  = rx_valid;
            end else if (is_io_cnt) begin
                mem_din_d = cnt_byte;
`ifdef COUNTER_SNAPSHOT_EN
                if (mem_a[1:0] == 2'd0) snap_d = cnt_q;
`endif
            end else begin
                mem_din_d = 8'h00;
            end
        end
        if (wr_en) begin
            if (is_io_uart) begin
                push_req = (mem_dout != 8'h00);
            end else if (is_io_cnt) begin
                // the stop write is the only way a 0x00 byte reaches the UART
                prog_stop_d = 1'b1;
                push_req    = 1'b1;
                push_byte   = 8'h00;
            end
        end
        // a pop in the same cycle frees the slot a full-FIFO push needs
        pop              = tx_vld & tx_ready;
        push_ok          = push_req & ((fifo_cnt_q != DEPTH_C) | pop);
        tx_overflow_d    = tx_overflow_q | (push_req & ~push_ok);
        fifo_cnt_d       = fifo_cnt_q + CW'(push_ok) - CW'(pop);
        wr_ptr_d         = wr_ptr_q + PW'(push_ok);
        rd_ptr_d         = rd_ptr_q + PW'(pop);
        io_buffer_full_d = (fifo_cnt_d >= FULL_AT);
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            mem_din_q        <= 8'h00;
            rx_ack_q         <= 1'b0;
            prog_stop_q      <= 1'b0;
            tx_overflow_q    <= 1'b0;
            io_buffer_full_q <= 1'b0;
            cnt_q            <= 32'd0;
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
            fifo_cnt_q       <= '0;
`ifdef COUNTER_SNAPSHOT_EN
            snap_q           <= 32'd0;
`endif
        end else begin
            cnt_q <= cnt_d;
            if (rdy_in) begin
                mem_din_q   <= mem_din_d;
                prog_stop_q <= prog_stop_d;
`ifdef COUNTER_SNAPSHOT_EN
                snap_q      <= snap_d;
`endif
            end
            rx_ack_q         <= rx_ack_d;
            tx_overflow_q    <= tx_overflow_d;
            io_buffer_full_q <= io_buffer_full_d;
            wr_ptr_q         <= wr_ptr_d;
            rd_ptr_q         <= rd_ptr_d;
            fifo_cnt_q       <= fifo_cnt_d;
        end
    end

    always_ff @(posedge clk_in) begin
        if (wr_en && is_ram) ram[mem_a[ADDR_WIDTH-1:0]] <= mem_dout;
        if (push_ok) tx_mem[wr_ptr_q] <= push_byte;
    end

    assign mem_din        = mem_din_q;
    assign rx_ack         = rx_ack_q;
    assign prog_stop      = prog_stop_q;
    assign tx_overflow    = tx_overflow_q;
    assign io_buffer_full = io_buffer_full_q;
    assign tx_valid       = tx_vld;
    assign tx_data        = tx_mem[rd_ptr_q];
endmodule
